// File: rtl/cmd_phy.sv
// Command-line PHY: serialises a 48-bit command frame with CRC7, then collects an
// optional 48/136-bit response and hands it to the controller through a strobe/ack handshake.
module cmd_phy #(
    parameter int RESP_TIMEOUT = 64
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         strobe_in,
    input  logic         ack_in,
    input  logic         idle_in,
    input  logic [39:0]  cmd_in,
    input  logic         cmd_pin_in,
    output logic         serial_ready,
    output logic         strobe_out,
    output logic         ack_out,
    output logic [135:0] cmd_out,
    output logic         TIMEOUT,
    output logic         crc_error,
    output logic         cmd_pin_out,
    output logic         cmd_oe
);

    localparam int TW = $clog2(RESP_TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT_RESP, RECEIVE, DONE, ACK} state_t;

    state_t         state_q;
    logic [46:0]    frame_q;
    logic [5:0]     idx_q;
    logic [135:0]   rx_q;
    logic [7:0]     cnt_q;
    logic [TW-1:0]  wait_q;
    logic           sready_q, strobe_q, ack_q, timeout_q, crc_err_q, pin_q, oe_q;

    // CRC7, x^7 + x^3 + 1, zero seed, MSB first
    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    logic [47:0]  frame_d;
    logic [135:0] rx_d;
    logic         no_resp, long_resp, rx_crc_bad;

    assign frame_d    = {cmd_in, crc7(cmd_in), 1'b1};
    assign rx_d       = {rx_q[134:0], cmd_pin_in};
    assign no_resp    = (idx_q == 6'd0) || (idx_q == 6'd4) || (idx_q == 6'd15);
    assign long_resp  = (idx_q == 6'd2) || (idx_q == 6'd9) || (idx_q == 6'd10);
    assign rx_crc_bad = crc7(rx_d[47:8]) != rx_d[7:1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            frame_q   <= '0;
            idx_q     <= '0;
            rx_q      <= '0;
            cnt_q     <= '0;
            wait_q    <= '0;
            sready_q  <= 1'b0;
            strobe_q  <= 1'b0;
            ack_q     <= 1'b0;
            timeout_q <= 1'b0;
            crc_err_q <= 1'b0;
            pin_q     <= 1'b1;
            oe_q      <= 1'b0;
        end else begin
            sready_q  <= 1'b0;
            ack_q     <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (strobe_in && !idle_in) begin
                        state_q  <= LOAD;
                        sready_q <= 1'b1;
                    end
                end
                LOAD: begin
                    frame_q <= frame_d[46:0];
                    idx_q   <= frame_d[45:40];
                    pin_q   <= frame_d[47];
                    oe_q    <= 1'b1;
                    rx_q    <= '0;
                    cnt_q   <= 8'd47;
                    state_q <= SEND;
                end
                SEND: begin
                    if (cnt_q == 8'd0) begin
                        oe_q   <= 1'b0;
                        pin_q  <= 1'b1;
                        wait_q <= '0;
                        if (no_resp) begin
                            state_q   <= DONE;
                            strobe_q  <= 1'b1;
                            crc_err_q <= 1'b0;
                        end else begin
                            state_q <= WAIT_RESP;
                        end
                    end else begin
                        cnt_q   <= cnt_q - 8'd1;
                        pin_q   <= frame_q[46];
                        frame_q <= {frame_q[45:0], 1'b0};
                    end
                end
                WAIT_RESP: begin
                    // the start bit is itself the first response bit
                    if (!cmd_pin_in) begin
                        rx_q    <= rx_d;
                        cnt_q   <= long_resp ? 8'd134 : 8'd46;
                        state_q <= RECEIVE;
                    end else if (wait_q == TW'(RESP_TIMEOUT - 2)) begin
                        timeout_q <= 1'b1;
                        state_q   <= IDLE;
                    end else begin
                        wait_q <= wait_q + TW'(1);
                    end
                end
                RECEIVE: begin
                    rx_q <= rx_d;
                    if (cnt_q == 8'd0) begin
                        state_q   <= DONE;
                        strobe_q  <= 1'b1;
                        crc_err_q <= !long_resp && (idx_q != 6'd41) && rx_crc_bad;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                DONE: begin
                    if (ack_in) begin
                        state_q   <= ACK;
                        strobe_q  <= 1'b0;
                        crc_err_q <= 1'b0;
                        ack_q     <= 1'b1;
                    end
                end
                ACK:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign serial_ready = sready_q;
    assign strobe_out   = strobe_q;
    assign ack_out      = ack_q;
    assign cmd_out      = rx_q;
    assign TIMEOUT      = timeout_q;
    assign crc_error    = crc_err_q;
    assign cmd_pin_out  = pin_q;
    assign cmd_oe       = oe_q;

endmodule
